// File: rtl/cla_serial_adder.sv
// ============================================================================
// Module      : cla_serial_adder (with arithmetic stage cla_4b)
// Description : Multi-word adder that adds one 4-bit nibble per clock through a
//               single 4-bit carry-lookahead stage, with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_4b (
  input  logic       CI,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       CO,
  output logic [3:0] S
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g    = A & B;
  assign w_p    = A ^ B;
  assign w_c[0] = CI;
  assign w_c[1] = w_g[0] | (w_p[0] & CI);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & CI);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & CI);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & CI);
  assign S      = w_p ^ w_c[3:0];
  assign CO     = w_c[4];
endmodule

module cla_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   ci,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   co,
  output logic                   busy
);
  localparam int c_W  = 4 * NIBBLES;
  localparam int c_IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_W-1:0]  r_a;
  logic [c_W-1:0]  r_b;
  logic [c_W-1:0]  r_sum;
  logic            r_carry;
  logic            r_co;
  logic [c_IW-1:0] r_idx;
  logic            w_accept;
  logic            w_last;
  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_s;
  logic            w_co;

  // Select the operand nibbles addressed by the running index.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == c_IW'(n)) begin
        w_a_nib = r_a[4*n +: 4];
        w_b_nib = r_b[4*n +: 4];
      end
    end
  end

  cla_4b u_cla (
    .CI (r_carry),
    .A  (w_a_nib),
    .B  (w_b_nib),
    .CO (w_co),
    .S  (w_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_idx == c_LAST_IDX);
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= ci;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == RUN) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (r_idx == c_IW'(n)) r_sum[4*n +: 4] <= w_s;
      end
      r_carry <= w_co;
      // Final nibble latches the carry-out; the index parks until the next accept.
      if (w_last) r_co <= w_co;
      else        r_idx <= r_idx + 1'b1;
    end
  end

  assign sum = r_sum;
  assign co  = r_co;
endmodule

`default_nettype wire

// File: tb/tb_cla_serial_adder.sv
// ============================================================================
// Module      : tb_cla_serial_adder
// Description : Self-checking bench for cla_serial_adder at NIBBLES = 4, 1, 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        in_valid4 = 0, out_ready4 = 0, ci4 = 0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, co4, busy4;
  logic [15:0] sum4;

  logic        in_valid1 = 0, out_ready1 = 0, ci1 = 0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        in_ready1, out_valid1, co1, busy1;
  logic [3:0]  sum1;

  logic        in_valid2 = 0, out_ready2 = 0, ci2 = 0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic        in_ready2, out_valid2, co2, busy2;
  logic [7:0]  sum2;

  cla_serial_adder #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .ci(ci4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .co(co4), .busy(busy4));

  cla_serial_adder #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .co(co1), .busy(busy1));

  cla_serial_adder #(.NIBBLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .ci(ci2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .co(co2), .busy(busy2));

  // Reference: plain integer addition truncated to w+1 bits.
  function automatic longint unsigned ref_add(input longint unsigned x, input longint unsigned y,
                                              input int c, input int w);
    return (x + y + longint'(c)) & ((64'd1 << (w + 1)) - 1);
  endfunction

  // One transaction on the 16-bit instance; entered and left on a falling edge in IDLE.
  task automatic run4(input logic [15:0] x, input logic [15:0] y, input logic c,
                      output logic [16:0] res, output int lat, output bit hs_bad);
    a4 = x; b4 = y; ci4 = c; in_valid4 = 1; out_ready4 = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 0;
    lat = 0; hs_bad = 0;
    while (!out_valid4 && lat < 50) begin
      if (in_ready4 || !busy4) hs_bad = 1;
      @(negedge clk);
      lat++;
    end
    if (in_ready4 || !busy4) hs_bad = 1;
    res = {co4, sum4};
    @(negedge clk);
  endtask

  task automatic run1(input logic [3:0] x, input logic [3:0] y, input logic c,
                      output logic [4:0] res, output int lat);
    a1 = x; b1 = y; ci1 = c; in_valid1 = 1; out_ready1 = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 0;
    lat = 0;
    while (!out_valid1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    res = {co1, sum1};
    @(negedge clk);
  endtask

  task automatic run2(input logic [7:0] x, input logic [7:0] y, input logic c,
                      output logic [8:0] res, output int lat);
    a2 = x; b2 = y; ci2 = c; in_valid2 = 1; out_ready2 = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 0;
    lat = 0;
    while (!out_valid2 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    res = {co2, sum2};
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready4, out_valid4, busy4, co4, sum4} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset4: got rdy=%b vld=%b busy=%b co=%b sum=%h, expected 1 0 0 0 0000",
               in_ready4, out_valid4, busy4, co4, sum4);
    end
    checks++;
    if ({in_ready1, out_valid1, busy1, co1, sum1, in_ready2, out_valid2, busy2, co2, sum2}
        !== {1'b1, 3'b000, 4'h0, 1'b1, 3'b000, 8'h00}) begin
      errors++;
      $display("FAIL reset1_2: got n1 %b%b%b%b%h n2 %b%b%b%b%h, expected 1000/0 1000/00",
               in_ready1, out_valid1, busy1, co1, sum1, in_ready2, out_valid2, busy2, co2, sum2);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [16:0] res; int lat; bit hs_bad;
    run4(16'h1234, 16'h4321, 1'b0, res, lat, hs_bad);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++;
    if (res !== 17'h05555) begin errors++; $display("FAIL basic_sum: got %h expected 05555", res); end
    checks++;
    if (hs_bad) begin errors++; $display("FAIL basic_handshake: in_ready high or busy low during RUN/DONE, expected rdy=0 busy=1"); end
    checks++;
    if ({in_ready4, out_valid4, busy4} !== 3'b100) begin
      errors++;
      $display("FAIL basic_return_idle: got rdy/vld/busy=%b expected 100", {in_ready4, out_valid4, busy4});
    end
  endtask

  task automatic test_carry();
    logic [16:0] res; int lat; bit hs_bad;
    logic [15:0] x, y; logic c;
    run4(16'hFFFF, 16'h0001, 1'b0, res, lat, hs_bad);
    checks++;
    if (res !== 17'(ref_add(64'hFFFF, 64'h1, 0, 16))) begin
      errors++; $display("FAIL carry_ripple: got %h expected 10000", res);
    end
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
      run4(x, y, c, res, lat, hs_bad);
      checks++;
      if (res !== 17'(ref_add(x, y, int'(c), 16)) || lat !== 4) begin
        errors++;
        $display("FAIL carry_random: %h+%h+%b got %h lat %0d expected %h lat 4",
                 x, y, c, res, lat, 17'(ref_add(x, y, int'(c), 16)));
      end
    end
    run4(16'hFFFF, 16'hFFFF, 1'b1, res, lat, hs_bad);
    checks++;
    if (res !== 17'h1FFFF) begin errors++; $display("FAIL carry_all_ones: got %h expected 1ffff", res); end
  endtask

  task automatic test_reset_midrun();
    logic [16:0] res; int lat; bit hs_bad;
    a4 = 16'hAAAA; b4 = 16'h5555; ci4 = 0; in_valid4 = 1; out_ready4 = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({in_ready4, out_valid4, busy4, co4, sum4} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_midrun: got rdy=%b vld=%b busy=%b co=%b sum=%h, expected 1 0 0 0 0000",
               in_ready4, out_valid4, busy4, co4, sum4);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run4(16'h0007, 16'h0009, 1'b0, res, lat, hs_bad);
    checks++;
    if (res !== 17'h00010 || lat !== 4) begin
      errors++; $display("FAIL after_reset: got %h lat %0d expected 00010 lat 4", res, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit unstable;
    a4 = 16'h00F0; b4 = 16'h0F10; ci4 = 0; in_valid4 = 1; out_ready4 = 0;
    @(posedge clk);
    @(negedge clk);
    a4 = 16'h1111; b4 = 16'h1111; ci4 = 1;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || {co4, sum4} !== 17'h01000) begin
      errors++; $display("FAIL bp_result: got %h lat %0d expected 01000 lat 4", {co4, sum4}, lat);
    end
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid4 || in_ready4 || {co4, sum4} !== 17'h01000) unstable = 1;
    end
    checks++;
    if (unstable) begin
      errors++; $display("FAIL bp_hold: got vld=%b rdy=%b res=%h, expected 1 0 01000 held", out_valid4, in_ready4, {co4, sum4});
    end
    in_valid4 = 0;
    out_ready4 = 1;
    @(negedge clk);
    checks++;
    if ({in_ready4, out_valid4, busy4, co4, sum4} !== {3'b100, 17'h01000}) begin
      errors++;
      $display("FAIL bp_release: got rdy/vld/busy=%b res=%h expected 100 01000",
               {in_ready4, out_valid4, busy4}, {co4, sum4});
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int when_q[$];
    int accepted = 0;
    bit fire;
    exp_q.push_back(17'(ref_add(64'h8000, 64'h8000, 0, 16)));
    exp_q.push_back(17'(ref_add(64'h7FFF, 64'h0001, 0, 16)));
    a4 = 16'h8000; b4 = 16'h8000; ci4 = 0; in_valid4 = 1; out_ready4 = 1;
    for (int n = 0; n < 30; n++) begin
      fire = in_valid4 && in_ready4;
      @(posedge clk);
      @(negedge clk);
      if (out_valid4) begin got_q.push_back({co4, sum4}); when_q.push_back(n); end
      if (fire) begin
        accepted++;
        if (accepted == 1) begin a4 = 16'h7FFF; b4 = 16'h0001; end
        else in_valid4 = 0;
      end
    end
    in_valid4 = 0;
    checks++;
    if (got_q.size() !== 2) begin
      errors++; $display("FAIL b2b_count: got %0d results expected 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b_result%0d: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (when_q[0] !== 4 || when_q[1] - when_q[0] !== 6) begin
        errors++;
        $display("FAIL b2b_spacing: got first %0d gap %0d expected first 4 gap 6", when_q[0], when_q[1] - when_q[0]);
      end
    end
  endtask

  task automatic test_sweep_n1();
    logic [4:0] res; int lat; logic [4:0] exp;
    for (int v = 0; v < 512; v++) begin
      run1(4'(v), 4'(v >> 4), 1'(v >> 8), res, lat);
      exp = 5'(ref_add(64'(v & 15), 64'((v >> 4) & 15), (v >> 8) & 1, 4));
      checks++;
      if (res !== exp || lat !== 1) begin
        errors++;
        $display("FAIL sweep_n1 v=%0d: got %h lat %0d expected %h lat 1", v, res, lat, exp);
      end
    end
  endtask

  task automatic test_random_n2();
    logic [8:0] res; int lat; logic [8:0] exp;
    logic [7:0] x, y; logic c;
    for (int v = 0; v < 2000; v++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      run2(x, y, c, res, lat);
      exp = 9'(ref_add(x, y, int'(c), 8));
      checks++;
      if (res !== exp || lat !== 2) begin
        errors++;
        $display("FAIL random_n2 %h+%h+%b: got %h lat %0d expected %h lat 2", x, y, c, res, lat, exp);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry();
    test_reset_midrun();
    test_backpressure();
    test_back_to_back();
    test_sweep_n1();
    test_random_n2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/cla_serial_adder.md
Name: cla_serial_adder

Overview:
- Multi-word adder built around the existing cla_4b (ports CI, A, B, CO, S) as its arithmetic stage.
- Accepts two W-bit operands plus carry-in through a valid/ready handshake.
- Drives one 4-bit nibble per clock through a single cla_4b instance, LSB nibble first, and registers the ripple carry between nibbles.
- Returns the W-bit sum and carry-out through a valid/ready handshake. Trades latency for area versus a flat wide CLA.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, ci valid
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- ci  input  1  carry-in for nibble 0
- out_valid  output  1  sum/co valid
- out_ready  input  1  consumer accepts result
- sum  output  W  result, a+b+ci modulo 2^W
- co  output  1  carry out of the MSB nibble
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_n low forces state IDLE immediately, independent of clk.
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, co=0. Internal operand regs, carry reg and nibble index are all 0.
- Structure: exactly one cla_4b instance.
  - A = a_reg[4*idx+3:4*idx], B = b_reg[4*idx+3:4*idx], CI = carry_reg.
  - No other adder logic is permitted in the datapath.
  - Nibble index width is clog2(NIBBLES), minimum 1.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture a_reg<=a, b_reg<=b, carry_reg<=ci; clear idx and sum_reg; go to RUN.
  - in_valid low: stay in IDLE.
- RUN:
  - in_ready=0.
  - Each cycle: sum_reg nibble idx <= S, carry_reg <= CO.
  - If idx==NIBBLES-1: co_reg <= CO and go to DONE. Otherwise idx <= idx+1.
  - in_valid is ignored; no operand capture.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and co are held stable while out_ready is low.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
- Latency:
  - Accept edge at cycle T. out_valid is high after edge T+NIBBLES (NIBBLES RUN cycles).
  - Minimum issue interval: NIBBLES+2 cycles with out_ready tied high.
- sum/co drive directly from registers. They are only meaningful while out_valid=1, and hold their last value after the result is consumed until the next run overwrites them.
- Arithmetic: {co,sum} = a + b + ci, exactly (W+1) bits, no saturation.
- NIBBLES=1: one RUN cycle, behaviour identical to a registered cla_4b.
- Simultaneous in_valid and out_ready in DONE: the new operands are not accepted that cycle. They are accepted on the following IDLE cycle if in_valid is still high.
- Reset mid-RUN or mid-DONE:
  - The operation is aborted and the result discarded.
  - All outputs return to reset values asynchronously.
  - After rst_n rises, the first accepted transaction is computed correctly.
- Operand inputs changing after acceptance have no effect on the in-flight result.

Test Plan:
- NIBBLES=4; a=16'h1234, b=16'h4321, ci=0, out_ready=1 -> out_valid high 4 cycles after the accept edge; sum=16'h5555, co=0; in_ready low throughout RUN/DONE.
- a=16'hFFFF, b=16'h0001, ci=0 -> carry ripples through all 4 nibbles; sum=16'h0000, co=1. Then a=16'hFFFF, b=16'hFFFF, ci=1 -> sum=16'hFFFF, co=1.
- Backpressure: a=16'h00F0, b=16'h0F10, ci=0, out_ready=0 for 5 cycles after out_valid -> sum=16'h1000, co=0 held stable. A new in_valid pulse with a=16'h1111 during RUN/DONE is ignored. On out_ready=1, the block returns to IDLE with in_ready=1.
- Reset: assert rst_n=0 two cycles into RUN of 16'hAAAA+16'h5555 -> out_valid=0, sum=0, co=0, in_ready=1 immediately. After release, 16'h0007+16'h0009, ci=0 -> sum=16'h0010, co=0.
- Back-to-back, in_valid held high and out_ready=1, with 16'h8000+16'h8000 then 16'h7FFF+16'h0001 -> results (co=1, sum=16'h0000) then (co=0, sum=16'h8000), spaced exactly 6 cycles apart.
- Sweep NIBBLES=1 over all 512 {a,b,ci} combinations, and NIBBLES=2 over 2000 random vectors -> every {co,sum} equals a+b+ci.
